// File: rtl/tdc_pkg.sv
// Shared types and default sizing for the TDC interval controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUNNING = 2'd2,
    DONE    = 2'd3
  } tdc_state_e;

  localparam int unsigned DEF_FINE_W       = 8;
  localparam int unsigned DEF_TAPS_PER_CLK = 200;
  localparam int unsigned DEF_COARSE_W     = 16;
  localparam int unsigned DEF_TIMEOUT      = 65535;

  // Interval width: coarse*taps needs COARSE_W+FINE_W bits, plus one bit of headroom for +start_fine.
  function automatic int unsigned out_w(input int unsigned coarse_w, input int unsigned fine_w);
    return coarse_w + fine_w + 1;
  endfunction

endpackage

// File: rtl/tdc_interval_ctrl_if.sv
// Control, channel strobes and result handshake of the TDC interval controller.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready; the result is held until accepted.
interface tdc_interval_ctrl_if import tdc_pkg::*; #(
  parameter int unsigned FINE_W   = DEF_FINE_W,
  parameter int unsigned COARSE_W = DEF_COARSE_W
) ();
  localparam int unsigned OUT_W = out_w(COARSE_W, FINE_W);

  logic                arm;
  logic                continuous;
  logic                start_valid;
  logic [FINE_W-1:0]   start_fine;
  logic                stop_valid;
  logic [FINE_W-1:0]   stop_fine;
  logic                out_valid;
  logic                out_ready;
  logic [OUT_W-1:0]    out_interval;
  logic [COARSE_W-1:0] out_coarse;
  logic                out_timeout;
  logic                out_range_err;
  logic                busy;
  logic [7:0]          missed_cnt;

  modport slave (
    input  arm, continuous, start_valid, start_fine, stop_valid, stop_fine, out_ready,
    output out_valid, out_interval, out_coarse, out_timeout, out_range_err, busy, missed_cnt
  );

  modport master (
    output arm, continuous, start_valid, start_fine, stop_valid, stop_fine, out_ready,
    input  out_valid, out_interval, out_coarse, out_timeout, out_range_err, busy, missed_cnt
  );
endinterface

// File: rtl/tdc_interval_calc.sv
// Result stage: coarse*TAPS_PER_CLK + start_fine - stop_fine, clamped at 0, with range check.
// Latency: 1 cycle from load to registered result.
// Backpressure: none; registers hold their value while load is low.
module tdc_interval_calc import tdc_pkg::*; #(
  parameter int unsigned FINE_W       = DEF_FINE_W,
  parameter int unsigned TAPS_PER_CLK = DEF_TAPS_PER_CLK,
  parameter int unsigned COARSE_W     = DEF_COARSE_W,
  parameter int unsigned OUT_W        = out_w(COARSE_W, FINE_W)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                load,
  input  logic                timeout,
  input  logic [COARSE_W-1:0] coarse,
  input  logic [FINE_W-1:0]   start_fine,
  input  logic [FINE_W-1:0]   stop_fine,
  output logic [OUT_W-1:0]    interval_q,
  output logic [COARSE_W-1:0] coarse_q,
  output logic                timeout_q,
  output logic                range_err_q
);
  // One extra bit so a negative difference shows up as a set MSB.
  typedef logic [OUT_W:0] wide_t;
  localparam wide_t TAPS_C = wide_t'(TAPS_PER_CLK);

  wide_t            diff;
  logic             start_bad, stop_bad, neg;
  logic [OUT_W-1:0] interval_d;
  logic             range_err_d;

  // Multiply-add, clamp and fine-code range check; a timeout has no stop code to subtract.
  always_comb begin
    diff        = wide_t'(coarse) * TAPS_C + wide_t'(start_fine) - wide_t'(stop_fine);
    neg         = diff[OUT_W];
    start_bad   = wide_t'(start_fine) >= TAPS_C;
    stop_bad    = wide_t'(stop_fine) >= TAPS_C;
    interval_d  = (timeout || neg) ? '0 : diff[OUT_W-1:0];
    range_err_d = start_bad || (!timeout && (stop_bad || neg));
  end

  // Capture the result only when the controller closes a measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_q  <= '0;
      coarse_q    <= '0;
      timeout_q   <= 1'b0;
      range_err_q <= 1'b0;
    end else if (load) begin
      interval_q  <= interval_d;
      coarse_q    <= coarse;
      timeout_q   <= timeout;
      range_err_q <= range_err_d;
    end
  end
endmodule

// File: rtl/tdc_interval_ctrl.sv
// Arm/measure/done controller turning start/stop fine codes plus a coarse count into an interval.
// Latency: result valid 1 cycle after the stop strobe (or after coarse reaches TIMEOUT).
// Backpressure: result held in DONE until out_ready; further starts are counted as missed.
module tdc_interval_ctrl import tdc_pkg::*; #(
  parameter int unsigned FINE_W       = DEF_FINE_W,
  parameter int unsigned TAPS_PER_CLK = DEF_TAPS_PER_CLK,
  parameter int unsigned COARSE_W     = DEF_COARSE_W,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT
) (
  input logic               clk,
  input logic               reset_n,
  tdc_interval_ctrl_if.slave bus
);
  typedef logic [COARSE_W-1:0] coarse_t;
  localparam coarse_t TIMEOUT_C = coarse_t'(TIMEOUT);

  tdc_state_e        state_q, state_d;
  coarse_t           coarse_q, coarse_d, coarse_inc;
  logic [FINE_W-1:0] start_fine_q, start_fine_d;
  logic [7:0]        missed_q, missed_d;
  logic              out_valid_q, out_valid_d;
  logic              calc_load, calc_timeout;
  coarse_t           calc_coarse;
  logic [FINE_W-1:0] calc_start_fine;

  assign coarse_inc = coarse_q + coarse_t'(1);

  // Next-state, coarse counter, missed-start counter and result-stage load.
  always_comb begin
    state_d         = state_q;
    coarse_d        = coarse_q;
    start_fine_d    = start_fine_q;
    missed_d        = missed_q;
    out_valid_d     = out_valid_q;
    calc_load       = 1'b0;
    calc_timeout    = 1'b0;
    calc_coarse     = coarse_inc;
    calc_start_fine = start_fine_q;

    if (bus.start_valid && (state_q == RUNNING || state_q == DONE) && missed_q != 8'hFF)
      missed_d = missed_q + 8'd1;

    case (state_q)
      IDLE: if (bus.arm) state_d = ARMED;
      ARMED: begin
        if (!bus.arm) begin
          state_d = IDLE;
        end else if (bus.start_valid) begin
          start_fine_d = bus.start_fine;
          coarse_d     = '0;
          if (bus.stop_valid) begin
            // Stop in the same cycle as start: zero coarse, result immediately.
            calc_load       = 1'b1;
            calc_coarse     = '0;
            calc_start_fine = bus.start_fine;
            out_valid_d     = 1'b1;
            state_d         = DONE;
          end else begin
            state_d = RUNNING;
          end
        end
      end
      RUNNING: begin
        coarse_d = coarse_inc;
        if (!bus.arm) begin
          coarse_d = '0;
          state_d  = IDLE;
        end else if (bus.stop_valid) begin
          calc_load   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (coarse_inc == TIMEOUT_C) begin
          calc_load    = 1'b1;
          calc_timeout = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = (bus.continuous && bus.arm) ? ARMED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      coarse_q     <= '0;
      start_fine_q <= '0;
      missed_q     <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      coarse_q     <= coarse_d;
      start_fine_q <= start_fine_d;
      missed_q     <= missed_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state_q == RUNNING) || (state_q == DONE);
  assign bus.missed_cnt = missed_q;

  tdc_interval_calc #(
    .FINE_W       (FINE_W),
    .TAPS_PER_CLK (TAPS_PER_CLK),
    .COARSE_W     (COARSE_W)
  ) u_calc (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (calc_load),
    .timeout     (calc_timeout),
    .coarse      (calc_coarse),
    .start_fine  (calc_start_fine),
    .stop_fine   (bus.stop_fine),
    .interval_q  (bus.out_interval),
    .coarse_q    (bus.out_coarse),
    .timeout_q   (bus.out_timeout),
    .range_err_q (bus.out_range_err)
  );
endmodule

// File: tb/tb_tdc_interval_ctrl.sv
// Self-checking bench for tdc_interval_ctrl (TIMEOUT shortened to 10 cycles).
// Latency: checks result one cycle after stop and at exactly TIMEOUT cycles.
// Backpressure: holds out_ready low and checks the result stays stable.
module tb_tdc_interval_ctrl;
  import tdc_pkg::*;

  localparam int FW = 8, CW = 16, TAPS = 200, TO = 10, OW = CW + FW + 1, RW = OW + CW + 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  tdc_interval_ctrl_if #(.FINE_W(FW), .COARSE_W(CW)) bus ();

  tdc_interval_ctrl #(.FINE_W(FW), .TAPS_PER_CLK(TAPS), .COARSE_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int vectors = 0, miscompares = 0, miss_exp = 0;
  logic early_vld;
  logic [RW-1:0] exp_r;

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  function automatic logic [RW-1:0] obs();
    return {bus.out_interval, bus.out_coarse, bus.out_timeout, bus.out_range_err};
  endfunction

  // Reference: d = cycles from start strobe to stop strobe; beyond TO the run times out.
  function automatic logic [RW-1:0] model(input int sf, input int pf, input int d);
    logic [OW-1:0] iv; logic [CW-1:0] co; logic to, er; int v;
    er = (sf >= TAPS);
    if (d > TO) begin
      iv = '0; co = CW'(TO); to = 1'b1;
    end else begin
      v = d * TAPS + sf - pf;
      to = 1'b0; co = CW'(d);
      if (pf >= TAPS) er = 1'b1;
      if (v < 0) begin er = 1'b1; v = 0; end
      iv = OW'(v);
    end
    return {iv, co, to, er};
  endfunction

  // Start strobe, then stop d cycles later (d=0 same cycle); optional stray starts while running.
  task automatic drive_meas(input int sf, input int pf, input int d, input int miss_pct);
    int lim;
    early_vld = 1'b0;
    bus.start_valid = 1'b1; bus.start_fine = sf[FW-1:0];
    if (d == 0) begin bus.stop_valid = 1'b1; bus.stop_fine = pf[FW-1:0]; end
    cyc();
    bus.start_valid = 1'b0; bus.stop_valid = 1'b0;
    lim = (d > TO) ? TO : d;
    for (int k = 1; k <= lim; k++) begin
      if (bus.out_valid !== 1'b0) early_vld = 1'b1;
      if (k == d) begin bus.stop_valid = 1'b1; bus.stop_fine = pf[FW-1:0]; end
      if (int'($urandom_range(99)) < miss_pct) begin
        bus.start_valid = 1'b1; bus.start_fine = FW'($urandom);
        if (miss_exp < 255) miss_exp++;
      end
      cyc();
      bus.start_valid = 1'b0; bus.stop_valid = 1'b0;
    end
  endtask

  task automatic ack();
    bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0; cyc();
  endtask

  task automatic test_reset();
    reset_n = 1'b1; #3 reset_n = 1'b0;
    cyc(); cyc();
    vectors++;
    if ({obs(), bus.out_valid, bus.busy, bus.missed_cnt} !== '0) begin
      miscompares++; $display("FAIL reset_values: got %h required 0", {obs(), bus.out_valid, bus.busy, bus.missed_cnt});
    end
    reset_n = 1'b1; cyc();
    vectors++;
    if ({bus.out_valid, bus.busy} !== 2'b00) begin
      miscompares++; $display("FAIL reset_release: valid/busy %b required 00", {bus.out_valid, bus.busy});
    end
  endtask

  task automatic test_basic();
    bus.arm = 1'b1; bus.continuous = 1'b0; cyc();
    drive_meas(150, 20, 3, 0);
    vectors++;
    if ({early_vld, bus.out_valid} !== 2'b01) begin
      miscompares++; $display("FAIL basic_latency: early/valid %b required 01", {early_vld, bus.out_valid});
    end
    vectors++;
    if (bus.out_interval !== OW'(730) || obs() !== model(150, 20, 3)) begin
      miscompares++; $display("FAIL basic_result: got %h required %h", obs(), model(150, 20, 3));
    end
    bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL basic_handshake: out_valid %b required 0", bus.out_valid);
    end
    // In IDLE a start is ignored and not counted; the state moves on to ARMED.
    bus.start_valid = 1'b1; bus.start_fine = 8'd5; cyc(); bus.start_valid = 1'b0;
    vectors++;
    if ({bus.busy, bus.missed_cnt} !== {1'b0, 8'd0}) begin
      miscompares++; $display("FAIL basic_idle_after: busy/missed %h required 000", {bus.busy, bus.missed_cnt});
    end
  endtask

  task automatic test_same_cycle();
    drive_meas(120, 40, 0, 0);
    vectors++;
    if ({bus.out_valid, obs()} !== {1'b1, model(120, 40, 0)}) begin
      miscompares++; $display("FAIL same_cycle: got %h required %h", {bus.out_valid, obs()}, {1'b1, model(120, 40, 0)});
    end
    ack();
  endtask

  task automatic test_timeout();
    drive_meas(50, 0, TO + 5, 0);
    vectors++;
    if ({early_vld, bus.out_valid, obs()} !== {2'b01, model(50, 0, TO + 5)}) begin
      miscompares++; $display("FAIL timeout_result: got %h required %h", {early_vld, bus.out_valid, obs()}, {2'b01, model(50, 0, TO + 5)});
    end
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if ({bus.busy, bus.out_valid} !== 2'b11) begin
        miscompares++; $display("FAIL timeout_busy: busy/valid %b required 11", {bus.busy, bus.out_valid});
      end
    end
    bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
    vectors++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL timeout_release: busy/valid %b required 00", {bus.busy, bus.out_valid});
    end
    cyc();
  endtask

  task automatic test_backpressure();
    bus.continuous = 1'b1;
    drive_meas(77, 150, 5, 0);
    exp_r = model(77, 150, 5);
    for (int i = 0; i < 5; i++) begin
      if (i == 1 || i == 3) begin bus.start_valid = 1'b1; bus.start_fine = 8'd9; miss_exp++; end
      cyc(); bus.start_valid = 1'b0;
      vectors++;
      if ({bus.out_valid, obs()} !== {1'b1, exp_r}) begin
        miscompares++; $display("FAIL hold_stable: got %h required %h", {bus.out_valid, obs()}, {1'b1, exp_r});
      end
    end
    vectors++;
    if (bus.missed_cnt !== 8'(miss_exp)) begin
      miscompares++; $display("FAIL hold_missed: got %0d required %0d", bus.missed_cnt, miss_exp);
    end
    bus.out_ready = 1'b1; cyc(); bus.out_ready = 1'b0;
    // continuous=1: back in ARMED, so an immediate start/stop pair must produce a result.
    drive_meas(30, 10, 0, 0);
    vectors++;
    if ({bus.out_valid, obs()} !== {1'b1, model(30, 10, 0)}) begin
      miscompares++; $display("FAIL continuous_rearm: got %h required %h", {bus.out_valid, obs()}, {1'b1, model(30, 10, 0)});
    end
    bus.continuous = 1'b0; ack();
  endtask

  task automatic test_range();
    drive_meas(210, 30, 2, 0);
    vectors++;
    if (obs() !== model(210, 30, 2) || bus.out_range_err !== 1'b1) begin
      miscompares++; $display("FAIL range_start: got %h required %h", obs(), model(210, 30, 2));
    end
    ack();
    drive_meas(10, 50, 0, 0);
    vectors++;
    if (obs() !== model(10, 50, 0) || bus.out_range_err !== 1'b1) begin
      miscompares++; $display("FAIL range_clamp: got %h required %h", obs(), model(10, 50, 0));
    end
    ack();
  endtask

  task automatic test_random();
    int sf, pf, d, hold;
    for (int n = 0; n < 40; n++) begin
      bus.continuous = 1'($urandom);
      sf = ($urandom_range(7) == 0) ? 200 + int'($urandom_range(55)) : int'($urandom_range(199));
      pf = ($urandom_range(7) == 0) ? 200 + int'($urandom_range(55)) : int'($urandom_range(199));
      d = int'($urandom_range(TO + 3));
      drive_meas(sf, pf, d, 25);
      exp_r = model(sf, pf, d);
      vectors++;
      if ({early_vld, bus.out_valid, obs()} !== {2'b01, exp_r}) begin
        miscompares++; $display("FAIL rand_result[%0d]: got %h required %h (sf=%0d pf=%0d d=%0d)", n, {early_vld, bus.out_valid, obs()}, {2'b01, exp_r}, sf, pf, d);
      end
      hold = int'($urandom_range(3));
      for (int h = 0; h <= hold; h++) begin
        bus.out_ready = (h == hold);
        if ($urandom_range(1) == 1) begin bus.start_valid = 1'b1; miss_exp++; end
        cyc(); bus.start_valid = 1'b0; bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== (h != hold)) begin
          miscompares++; $display("FAIL rand_valid[%0d]: got %b required %b", n, bus.out_valid, h != hold);
        end
      end
      cyc();
      vectors++;
      if (bus.missed_cnt !== 8'(miss_exp)) begin
        miscompares++; $display("FAIL rand_missed[%0d]: got %0d required %0d", n, bus.missed_cnt, miss_exp);
      end
    end
    bus.continuous = 1'b0;
  endtask

  task automatic test_missed_sat();
    drive_meas(1, 1, 1, 0);
    bus.start_valid = 1'b1;
    for (int i = 0; i < 300; i++) cyc();
    bus.start_valid = 1'b0;
    miss_exp = (miss_exp + 300 > 255) ? 255 : miss_exp + 300;
    vectors++;
    if (bus.missed_cnt !== 8'(miss_exp)) begin
      miscompares++; $display("FAIL missed_saturate: got %0d required %0d", bus.missed_cnt, miss_exp);
    end
    ack();
  endtask

  task automatic test_reset_abort();
    bus.start_valid = 1'b1; bus.start_fine = 8'd100; cyc(); bus.start_valid = 1'b0;
    cyc(); cyc();
    vectors++;
    if (bus.busy !== 1'b1) begin
      miscompares++; $display("FAIL abort_running: busy %b required 1", bus.busy);
    end
    reset_n = 1'b0; #1;
    miss_exp = 0;
    vectors++;
    if ({obs(), bus.out_valid, bus.busy, bus.missed_cnt} !== '0) begin
      miscompares++; $display("FAIL midrun_reset: got %h required 0", {obs(), bus.out_valid, bus.busy, bus.missed_cnt});
    end
    cyc(); reset_n = 1'b1; cyc();
    bus.start_valid = 1'b1; bus.start_fine = 8'd60; cyc(); bus.start_valid = 1'b0;
    cyc();
    bus.arm = 1'b0; cyc();
    vectors++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL arm_abort: busy/valid %b required 00", {bus.busy, bus.out_valid});
    end
    bus.arm = 1'b1; cyc();
    bus.stop_valid = 1'b1; bus.stop_fine = 8'd3; cyc(); bus.stop_valid = 1'b0;
    cyc();
    vectors++;
    if ({bus.busy, bus.out_valid, bus.missed_cnt} !== 10'd0) begin
      miscompares++; $display("FAIL abort_no_result: got %h required 0", {bus.busy, bus.out_valid, bus.missed_cnt});
    end
  endtask

  initial begin
    bus.arm = 1'b0; bus.continuous = 1'b0; bus.out_ready = 1'b0;
    bus.start_valid = 1'b0; bus.start_fine = '0; bus.stop_valid = 1'b0; bus.stop_fine = '0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_timeout();
    test_backpressure();
    test_range();
    test_random();
    test_missed_sat();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
